uart_rx_fifo: RTL

//  8N1 UART receiver with receive FIFO. It is the other end of the SoC serial link: it decodes
//  the txd stream driven by soc_m3_top (or the host line on rxd) and buffers the bytes.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_fifo_if.sv | 36 +++
 rtl/uart_rx_fifo_sync_fifo.sv | 60 ++++++
 rtl/uart_rx_fifo.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_rx_fifo (and the future uart_tx).
// Contents: receiver state enum, data width and default oversample constants,
// and the baud divider helper.
package uart_pkg;

  localparam int unsigned UART_DATA_W  = 8;
  localparam int unsigned UART_OVS_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_t;

  // Clock cycles per oversample tick: round(clk_hz / (baud * ovs)), never below 1.
  function automatic int unsigned uart_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned ovs);
    longint unsigned den;
    longint unsigned q;
    den = longint'(baud) * longint'(ovs);
    if (den == 0) return 1;
    q = (longint'(clk_hz) + den / 2) / den;
    if (q < 1) q = 1;
    return int'(q);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte-stream and status bundle between the UART receiver and its consumer.
//   rx_data     FIFO head byte            (receiver -> consumer)
//   rx_valid    FIFO not empty            (receiver -> consumer)
//   rx_ready    pop the head              (consumer -> receiver)
//   frame_err   1-cycle bad-stop pulse    (receiver -> consumer)
//   overrun     sticky dropped-byte flag  (receiver -> consumer)
//   overrun_clr clears overrun            (consumer -> receiver)
//   fifo_level  occupied entries          (receiver -> consumer)
// master = receiver side, slave = consumer side.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) ();

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [UART_DATA_W-1:0] rx_data;
  logic                   rx_valid;
  logic                   rx_ready;
  logic                   frame_err;
  logic                   overrun;
  logic                   overrun_clr;
  logic [LVL_W-1:0]       fifo_level;

  modport master (
    output rx_data, rx_valid, frame_err, overrun, fifo_level,
    input  rx_ready, overrun_clr
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, overrun, fifo_level,
    output rx_ready, overrun_clr
  );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word fall-through synchronous FIFO.
//   clk, rst  clock, asynchronous active-high reset
//   push/din  write request and data; ignored when full unless a pop happens in the same cycle
//   pop       read request; ignored when empty
//   dout      head entry, forced to 0 while empty
//   full, empty, level  occupancy status
// A push into an empty FIFO is not bypassed to dout; it appears the next cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [LVL_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == LVL_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // When full, the slot freed by a simultaneous pop takes the new entry.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= din;
  end

  // Storage is not reset, so the head is masked while nothing valid is held.
  assign dout  = empty ? '0 : mem[rptr_q];
  assign level = cnt_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with receive FIFO.
//   clk     core clock
//   rst     asynchronous active-high reset
//   rxd     serial input, asynchronous, idle high
//   rxdled  high while the receiver is outside IDLE
//   bus     byte stream and status (rx_data, rx_valid, rx_ready, frame_err, overrun,
//           overrun_clr, fifo_level)
// Holds the input synchronizer, oversample tick generator, framing FSM and overrun flag;
// buffering rules live in sync_fifo.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVS        = UART_OVS_DEF,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxd,
  output logic             rxdled,
  uart_rx_fifo_if.master   bus
);

  localparam int unsigned DIV   = uart_div(CLK_HZ, BAUD, OVS);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OVS_W = $clog2(OVS);
  localparam int unsigned BIT_W = $clog2(UART_DATA_W);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  logic sync1_q, rxs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rxs_q   <= sync1_q;
    end
  end

  // Free-running oversample tick.
  logic [DIV_W-1:0] div_q;
  logic             tick;

  assign tick = (div_q == DIV_W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_q <= '0;
    else     div_q <= tick ? '0 : div_q + 1'b1;
  end

  // Framing FSM.
  uart_state_t            state_q, state_d;
  logic [OVS_W-1:0]       ovs_q, ovs_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [UART_DATA_W-1:0] sh_q, sh_d;
  logic                   ovs_wrap;
  logic                   push;
  logic                   frame_err;

  always_comb begin
    state_d   = state_q;
    ovs_d     = ovs_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    push      = 1'b0;
    frame_err = 1'b0;

    ovs_wrap = tick && (ovs_q == OVS_W'(OVS - 1));
    if (tick) ovs_d = ovs_wrap ? '0 : ovs_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d = START;
          ovs_d   = '0;
        end
      end
      START: begin
        // Mid-bit check of the start bit rejects short glitches.
        if (tick && (ovs_q == OVS_W'(OVS / 2 - 1))) begin
          if (rxs_q) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = '0;
            ovs_d   = '0;
          end
        end
      end
      DATA: begin
        if (ovs_wrap) begin
          sh_d  = {rxs_q, sh_q[UART_DATA_W-1:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == BIT_W'(UART_DATA_W - 1)) state_d = STOP;
        end
      end
      STOP: begin
        if (ovs_wrap) begin
          if (rxs_q) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = BREAK;
          end
        end
      end
      BREAK: begin
        // Hold off until the line returns high so a break is not read as start bits.
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ovs_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      ovs_q   <= ovs_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  // Receive FIFO.
  logic [UART_DATA_W-1:0] fifo_dout;
  logic                   fifo_full, fifo_empty;
  logic [LVL_W-1:0]       fifo_lvl;

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (bus.rx_ready),
    .din   (sh_q),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_lvl)
  );

  // Overrun: a byte is lost only if full and not popped that cycle; a new set beats a clear.
  logic overrun_q, overrun_set;

  assign overrun_set = push & fifo_full & ~bus.rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun_q <= 1'b0;
    else     overrun_q <= overrun_set | (overrun_q & ~bus.overrun_clr);
  end

  assign bus.rx_data    = fifo_dout;
  assign bus.rx_valid   = ~fifo_empty;
  assign bus.fifo_level = fifo_lvl;
  assign bus.frame_err  = frame_err;
  assign bus.overrun    = overrun_q;
  assign rxdled         = (state_q != IDLE);

endmodule
